// File: rtl/fwd_pkg.sv
`default_nettype none
// ===========================================================================
// fwd_pkg : shared select/state encodings for the forwarding controller
// rev 1.0
// ===========================================================================
package fwd_pkg;

   localparam int FWD_SEL_W = 2;

   typedef enum logic [FWD_SEL_W-1:0] {
      NO_FWD   = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10,
      FWD_HOLD = 2'b11
   } fwd_sel_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } hz_state_e;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/forward_src_mux.sv
`default_nettype none
// ===========================================================================
// forward_src_mux : one EX source operand, priority select and 4:1 data mux
// rev 1.0
// ===========================================================================
module forward_src_mux
   import fwd_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] rs_addr_i,
   input  logic [XLEN-1:0] rsdata_i,
   input  logic [RA_W-1:0] mem_rd_addr_i,
   input  logic            mem_regwen_i,
   input  logic [XLEN-1:0] mem_aludata_i,
   input  logic [RA_W-1:0] wb_rd_addr_i,
   input  logic            wb_regwen_i,
   input  logic [XLEN-1:0] wb_wbdata_i,
   input  logic            hold_vld_i,
   input  logic [RA_W-1:0] hold_addr_i,
   input  logic [XLEN-1:0] hold_data_i,
   output fwd_sel_e        sel_o,
   output logic [XLEN-1:0] data_o
);

   // Youngest producer first; x0 is never forwarded.
   always_comb begin
      sel_o = NO_FWD;
      if (rs_addr_i != '0) begin
         if (mem_regwen_i && (mem_rd_addr_i == rs_addr_i)) begin
            sel_o = FWD_MEM;
         end else if (wb_regwen_i && (wb_rd_addr_i == rs_addr_i)) begin
            sel_o = FWD_WB;
         end else if (hold_vld_i && (hold_addr_i == rs_addr_i)) begin
            sel_o = FWD_HOLD;
         end
      end
   end

   always_comb begin
      data_o = rsdata_i;
      case (sel_o)
         FWD_MEM:  data_o = mem_aludata_i;
         FWD_WB:   data_o = wb_wbdata_i;
         FWD_HOLD: data_o = hold_data_i;
         default:  data_o = rsdata_i;
      endcase
   end

endmodule : forward_src_mux
`default_nettype wire

// File: rtl/forward_ctrl_unit.sv
`default_nettype none
// ===========================================================================
// forward_ctrl_unit : EX operand forwarding and load-use stall/bubble control
// rev 1.0
// ===========================================================================
module forward_ctrl_unit
   import fwd_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_SRC  = 2,
   parameter int RA_W     = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             id_valid_i,
   input  logic [NUM_SRC-1:0][RA_W-1:0]     id_rs_addr_i,
   input  logic                             ex_valid_i,
   input  logic [RA_W-1:0]                  ex_rd_addr_i,
   input  logic                             ex_regwen_i,
   input  logic                             ex_is_load_i,
   input  logic [NUM_SRC-1:0][RA_W-1:0]     ex_rs_addr_i,
   input  logic [NUM_SRC-1:0][XLEN-1:0]     ex_rsdata_i,
   input  logic [RA_W-1:0]                  mem_rd_addr_i,
   input  logic                             mem_regwen_i,
   input  logic [XLEN-1:0]                  mem_aludata_i,
   input  logic [RA_W-1:0]                  wb_rd_addr_i,
   input  logic                             wb_regwen_i,
   input  logic [XLEN-1:0]                  wb_wbdata_i,
   output logic [NUM_SRC-1:0][XLEN-1:0]     rs_data_o,
   output logic [NUM_SRC-1:0][FWD_SEL_W-1:0] fwd_sel_o,
   output logic                             stall_o,
   output logic                             flush_ex_o
);

   localparam int CNT_W = $clog2(LOAD_LAT + 1);

   if (LOAD_LAT < 1 || LOAD_LAT > 2) begin : g_bad_load_lat
      $error("forward_ctrl_unit: LOAD_LAT must be 1 or 2");
   end
   if (NUM_SRC < 1 || NUM_SRC > 3) begin : g_bad_num_src
      $error("forward_ctrl_unit: NUM_SRC must be 1..3");
   end

   logic            hold_vld_q;
   logic [RA_W-1:0] hold_addr_q;
   logic [XLEN-1:0] hold_data_q;

   // Keeps last cycle's WB result for a consumer that reaches EX one cycle late.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_vld_q  <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
      end else begin
         hold_vld_q  <= wb_regwen_i && (wb_rd_addr_i != '0);
         hold_addr_q <= wb_rd_addr_i;
         hold_data_q <= wb_wbdata_i;
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_sel_e sel;

      forward_src_mux #(
         .XLEN (XLEN),
         .RA_W (RA_W)
      ) u_mux (
         .rs_addr_i     (ex_rs_addr_i[g]),
         .rsdata_i      (ex_rsdata_i[g]),
         .mem_rd_addr_i (mem_rd_addr_i),
         .mem_regwen_i  (mem_regwen_i),
         .mem_aludata_i (mem_aludata_i),
         .wb_rd_addr_i  (wb_rd_addr_i),
         .wb_regwen_i   (wb_regwen_i),
         .wb_wbdata_i   (wb_wbdata_i),
         .hold_vld_i    (hold_vld_q),
         .hold_addr_i   (hold_addr_q),
         .hold_data_i   (hold_data_q),
         .sel_o         (sel),
         .data_o        (rs_data_o[g])
      );

      assign fwd_sel_o[g] = sel;
   end

   logic src_match;
   logic hazard;

   always_comb begin
      src_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_addr_i[i] == ex_rd_addr_i) begin
            src_match = 1'b1;
         end
      end
   end

   assign hazard = id_valid_i && ex_valid_i && ex_is_load_i && ex_regwen_i &&
                   (ex_rd_addr_i != '0) && src_match;

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The IDLE hazard cycle is the first stall cycle; STALL covers the rest.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (hazard && (LOAD_LAT > 1)) begin
               state_d = STALL;
               cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:    stall = hazard;
         STALL:   stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   // Gated by reset so the Mealy path cannot assert while reset is held.
   assign stall_o    = rst_ni && stall;
   assign flush_ex_o = rst_ni && stall;

endmodule : forward_ctrl_unit
`default_nettype wire

// File: tb/tb_forward_ctrl_unit.sv
`default_nettype none
// ===========================================================================
// tb_forward_ctrl_unit : scoreboard bench, LOAD_LAT=1 and LOAD_LAT=2 side by side
// rev 1.0
// ===========================================================================
module tb_forward_ctrl_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             id_valid;
   logic [1:0][4:0]  id_rs;
   logic             ex_valid;
   logic [4:0]       ex_rd;
   logic             ex_regwen;
   logic             ex_is_load;
   logic [1:0][4:0]  ex_rs;
   logic [1:0][31:0] ex_rsdata;
   logic [4:0]       mem_rd;
   logic             mem_regwen;
   logic [31:0]      mem_alu;
   logic [4:0]       wb_rd;
   logic             wb_regwen;
   logic [31:0]      wb_data;

   logic [1:0][31:0] a_data, b_data;
   logic [1:0][1:0]  a_sel, b_sel;
   logic             a_stall, a_flush, b_stall, b_flush;

   forward_ctrl_unit #(.XLEN(32), .NUM_SRC(2), .RA_W(5), .LOAD_LAT(1)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs),
      .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_regwen_i(ex_regwen),
      .ex_is_load_i(ex_is_load), .ex_rs_addr_i(ex_rs), .ex_rsdata_i(ex_rsdata),
      .mem_rd_addr_i(mem_rd), .mem_regwen_i(mem_regwen), .mem_aludata_i(mem_alu),
      .wb_rd_addr_i(wb_rd), .wb_regwen_i(wb_regwen), .wb_wbdata_i(wb_data),
      .rs_data_o(a_data), .fwd_sel_o(a_sel), .stall_o(a_stall), .flush_ex_o(a_flush)
   );

   forward_ctrl_unit #(.XLEN(32), .NUM_SRC(2), .RA_W(5), .LOAD_LAT(2)) u_lat2 (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs),
      .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_regwen_i(ex_regwen),
      .ex_is_load_i(ex_is_load), .ex_rs_addr_i(ex_rs), .ex_rsdata_i(ex_rsdata),
      .mem_rd_addr_i(mem_rd), .mem_regwen_i(mem_regwen), .mem_aludata_i(mem_alu),
      .wb_rd_addr_i(wb_rd), .wb_regwen_i(wb_regwen), .wb_wbdata_i(wb_data),
      .rs_data_o(b_data), .fwd_sel_o(b_sel), .stall_o(b_stall), .flush_ex_o(b_flush)
   );

   localparam logic [1:0] S_NO = 2'b00, S_MEM = 2'b01, S_WB = 2'b10, S_HOLD = 2'b11;
   localparam logic [31:0] RF0 = 32'h0000_1000, RF1 = 32'h0000_2000;

   typedef struct {
      string       name;
      logic [31:0] d0, d1;
      logic [1:0]  s0, s1;
      logic        st1, st2;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, fld, act, exp);
      end
   endtask

   // Monitor: one expected entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "l1_d0", a_data[0], e.d0);
         chk(e.name, "l1_d1", a_data[1], e.d1);
         chk(e.name, "l1_s0", 32'(a_sel[0]), 32'(e.s0));
         chk(e.name, "l1_s1", 32'(a_sel[1]), 32'(e.s1));
         chk(e.name, "l2_d0", b_data[0], e.d0);
         chk(e.name, "l2_d1", b_data[1], e.d1);
         chk(e.name, "l2_s0", 32'(b_sel[0]), 32'(e.s0));
         chk(e.name, "l2_s1", 32'(b_sel[1]), 32'(e.s1));
         chk(e.name, "l1_stall", 32'(a_stall), 32'(e.st1));
         chk(e.name, "l1_flush", 32'(a_flush), 32'(e.st1));
         chk(e.name, "l2_stall", 32'(b_stall), 32'(e.st2));
         chk(e.name, "l2_flush", 32'(b_flush), 32'(e.st2));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      id_valid = 1'b0; id_rs = '0;
      ex_valid = 1'b0; ex_rd = '0; ex_regwen = 1'b0; ex_is_load = 1'b0;
      ex_rs = '0; ex_rsdata[0] = RF0; ex_rsdata[1] = RF1;
      mem_rd = '0; mem_regwen = 1'b0; mem_alu = '0;
      wb_rd = '0; wb_regwen = 1'b0; wb_data = '0;
   endtask

   task automatic expect_v(input string name, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic st1, input logic st2);
      exp_t e;
      e.name = name; e.d0 = d0; e.d1 = d1; e.s0 = s0; e.s1 = s1; e.st1 = st1; e.st2 = st2;
      q.push_back(e);
   endtask

   task automatic load_hazard(input logic [4:0] rd);
      id_valid = 1'b1; id_rs[0] = rd; id_rs[1] = rd;
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_regwen = 1'b1; ex_rd = rd;
   endtask

   initial begin
      // Held in reset with a live hazard and a MEM match.
      step(); rst_n = 1'b0;
      load_hazard(5'd7);
      ex_rs[0] = 5'd5; mem_rd = 5'd5; mem_regwen = 1'b1; mem_alu = 32'h11;
      expect_v("in_reset", 32'h11, RF1, S_MEM, S_NO, 1'b0, 1'b0);

      step(); rst_n = 1'b1;
      ex_rs[0] = 5'd5; mem_rd = 5'd5; mem_regwen = 1'b1; mem_alu = 32'h11;
      wb_rd = 5'd5; wb_regwen = 1'b1; wb_data = 32'h22;
      expect_v("mem_over_wb", 32'h11, RF1, S_MEM, S_NO, 1'b0, 1'b0);

      step(); ex_rs[0] = 5'd5; mem_rd = 5'd0; mem_regwen = 1'b1; mem_alu = 32'h33;
      expect_v("x0_and_hold", 32'h22, RF1, S_HOLD, S_NO, 1'b0, 1'b0);

      step(); ex_rs[0] = 5'd9; ex_rs[1] = 5'd9; wb_rd = 5'd9; wb_regwen = 1'b1; wb_data = 32'h44;
      expect_v("wb_both", 32'h44, 32'h44, S_WB, S_WB, 1'b0, 1'b0);

      step(); ex_rs[0] = 5'd9; ex_rs[1] = 5'd9; mem_rd = 5'd9; mem_regwen = 1'b1; mem_alu = 32'h55;
      expect_v("mem_over_hold", 32'h55, 32'h55, S_MEM, S_MEM, 1'b0, 1'b0);

      step(); load_hazard(5'd7); ex_valid = 1'b0;
      expect_v("no_ex_valid", RF0, RF1, S_NO, S_NO, 1'b0, 1'b0);

      step(); load_hazard(5'd7); id_valid = 1'b0;
      expect_v("no_id_valid", RF0, RF1, S_NO, S_NO, 1'b0, 1'b0);

      step(); load_hazard(5'd0);
      expect_v("load_to_x0", RF0, RF1, S_NO, S_NO, 1'b0, 1'b0);

      step(); load_hazard(5'd7);
      expect_v("hz1_cyc0", RF0, RF1, S_NO, S_NO, 1'b1, 1'b1);

      step(); load_hazard(5'd7); ex_valid = 1'b0;
      ex_rs[0] = 5'd7; ex_rs[1] = 5'd7; wb_rd = 5'd7; wb_regwen = 1'b1; wb_data = 32'hAB;
      expect_v("hz1_cyc1", 32'hAB, 32'hAB, S_WB, S_WB, 1'b0, 1'b1);

      step(); ex_valid = 1'b1; ex_rs[0] = 5'd7; ex_rs[1] = 5'd7;
      expect_v("hz1_hold", 32'hAB, 32'hAB, S_HOLD, S_HOLD, 1'b0, 1'b0);

      step(); load_hazard(5'd3); id_rs[1] = 5'd0;
      expect_v("b2b_a", RF0, RF1, S_NO, S_NO, 1'b1, 1'b1);
      step(); load_hazard(5'd3); id_rs[1] = 5'd0;
      expect_v("b2b_b", RF0, RF1, S_NO, S_NO, 1'b1, 1'b1);
      step(); load_hazard(5'd3); id_rs[1] = 5'd0;
      expect_v("b2b_c", RF0, RF1, S_NO, S_NO, 1'b1, 1'b1);

      // Reset lands in the second stall cycle of the LOAD_LAT=2 instance.
      step(); rst_n = 1'b0; load_hazard(5'd3);
      ex_rs[0] = 5'd3; wb_rd = 5'd3; wb_regwen = 1'b1; wb_data = 32'h77;
      expect_v("rst_in_stall", 32'h77, RF1, S_WB, S_NO, 1'b0, 1'b0);

      step(); rst_n = 1'b1; ex_rs[0] = 5'd3;
      expect_v("post_rst_hold", RF0, RF1, S_NO, S_NO, 1'b0, 1'b0);

      step(); load_hazard(5'd4);
      expect_v("post_rst_hz", RF0, RF1, S_NO, S_NO, 1'b1, 1'b1);
      step();
      expect_v("post_rst_stall", RF0, RF1, S_NO, S_NO, 1'b0, 1'b1);
      step();
      expect_v("post_rst_idle", RF0, RF1, S_NO, S_NO, 1'b0, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_forward_ctrl_unit
`default_nettype wire

// File: doc/forward_ctrl_unit.md
# forward_ctrl_unit

Parametrised forwarding and load-use hazard controller for the RV32I pipeline. It compares EX-stage source registers against MEM, WB and a one-entry WB-hold register, then drives the EX operand values for `NUM_SRC` sources. It detects load-use hazards between ID and EX and drives a multi-cycle stall/bubble sequence sized by `LOAD_LAT`. It sits between the ID/EX pipeline register and the ALU operand muxes, and feeds the hazard inputs of the PC, IF/ID and ID/EX registers.

## Interface
- `XLEN`, 32, datapath width.
- `NUM_SRC`, 2, number of forwarded source operands (1..3).
- `RA_W`, 5, register address width.
- `LOAD_LAT`, 1, stall cycles per load-use hazard (1 or 2); elaborate-time assertion otherwise.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `id_valid_i` in 1: ID instruction valid.
- `id_rs_addr_i` in `NUM_SRC`×`RA_W`: ID source addresses.
- `ex_valid_i` in 1: EX instruction valid.
- `ex_rd_addr_i` in `RA_W`: EX destination.
- `ex_regwen_i` in 1: EX writes the register file.
- `ex_is_load_i` in 1: EX instruction is a load.
- `ex_rs_addr_i` in `NUM_SRC`×`RA_W`: EX source addresses.
- `ex_rsdata_i` in `NUM_SRC`×`XLEN`: register-file data latched in ID/EX.
- `mem_rd_addr_i` in `RA_W`, `mem_regwen_i` in 1, `mem_aludata_i` in `XLEN`: MEM producer.
- `wb_rd_addr_i` in `RA_W`, `wb_regwen_i` in 1, `wb_wbdata_i` in `XLEN`: WB producer.
- `rs_data_o` out `NUM_SRC`×`XLEN`: forwarded operands.
- `fwd_sel_o` out `NUM_SRC`×2: per-source select, for debug/trace.
- `stall_o` out 1: hold PC and IF/ID.
- `flush_ex_o` out 1: load a bubble into ID/EX.

## Operation
- Select per source i, first match wins:
  1. MEM, when `mem_regwen_i` and `mem_rd_addr_i == ex_rs_addr_i[i]`.
  2. WB, when `wb_regwen_i` and `wb_rd_addr_i == ex_rs_addr_i[i]`.
  3. HOLD, when `hold_vld` and `hold_addr == ex_rs_addr_i[i]`.
  4. Otherwise NONE.
- Address 0 never matches; select is NONE and `rs_data_o` equals `ex_rsdata_i` (x0 is already 0).
- `rs_data_o[i]` per select: NONE → `ex_rsdata_i[i]`, MEM → `mem_aludata_i`, WB → `wb_wbdata_i`, HOLD → `hold_data`. Combinational, no latency.
- WB-hold register: each cycle, `hold_vld <= wb_regwen_i && wb_rd_addr_i != 0`, `hold_addr <= wb_rd_addr_i`, `hold_data <= wb_wbdata_i`. It covers a producer that retired one cycle before the consumer reached EX, which happens only when `LOAD_LAT == 2`.
- Hazard: `id_valid_i && ex_valid_i && ex_is_load_i && ex_regwen_i && ex_rd_addr_i != 0`, and `ex_rd_addr_i` equals any `id_rs_addr_i[i]`. A match on several sources counts as one hazard.
- FSM states IDLE and STALL, with counter `cnt` of width $clog2(LOAD_LAT+1).
  - IDLE with hazard: `stall_o = flush_ex_o = 1` in the same cycle (Mealy). If `LOAD_LAT == 2`, go to STALL with `cnt = 1`; otherwise stay in IDLE.
  - STALL: `stall_o = flush_ex_o = 1`. Hazard detection is ignored. `cnt` decrements each cycle; the FSM returns to IDLE after the cycle in which `cnt` reaches 0.
- Total stall length is exactly `LOAD_LAT` cycles per hazard.
- Back-to-back: a new hazard can be flagged in the first IDLE cycle after STALL.

## Timing
- Reset values: state IDLE, `cnt` 0, `hold_vld` 0, `hold_addr` 0, `hold_data` 0.
- During reset, `stall_o` and `flush_ex_o` are 0, and `fwd_sel_o` and `rs_data_o` follow the combinational rules with `hold_vld` 0.
- Reset asserted mid-STALL: the FSM leaves STALL asynchronously; `stall_o` drops in the same cycle.
- Forwarding path: zero cycles. Stall assertion: zero cycles from hazard detection. Hold register: one cycle.
- MEM and WB match the same address: MEM wins, because it is the younger producer.

## Structure
- `fwd_pkg` holds:
  - `fwd_sel_e`: `NO_FWD`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10, `FWD_HOLD`=2'b11.
  - `hz_state_e`: IDLE, STALL.
- Sub-module `forward_src_mux`: per-source 4:1 operand mux plus its select logic. It is instantiated `NUM_SRC` times in a generate loop. FSM, hazard detection and the hold register stay in the top level.

## Test plan
- EX rs1=5; MEM rd=5, regwen, alu=0x11; WB rd=5, regwen, wb=0x22 → `fwd_sel_o[0]`=`FWD_MEM`, `rs_data_o[0]`=0x11.
- EX rs2=0; MEM rd=0 with regwen → `fwd_sel_o[1]`=`NO_FWD`, `rs_data_o[1]`=`ex_rsdata_i[1]`.
- `LOAD_LAT`=1: EX load rd=7, ID rs1=7 and rs2=7 → `stall_o`/`flush_ex_o` high exactly 1 cycle. Next cycle, with the consumer in EX and WB rd=7 data 0xAB → `rs_data_o[0]`=0xAB.
- `LOAD_LAT`=2: same hazard → stall 2 cycles. Consumer in EX with WB empty and previous-cycle WB rd=7 data 0xCD → `FWD_HOLD`, `rs_data_o`=0xCD.
- `LOAD_LAT`=2: assert `rst_ni` low in the second stall cycle → `stall_o`=0 immediately. After release, FSM is IDLE and `hold_vld`=0.
- Hazard with `ex_valid_i`=0 or `id_valid_i`=0 → no stall.
